// File: rtl/wb_pkg.sv
// Shared types and field layout for the posted-write buffer.
// A FIFO entry packs {addr, size, wdata} into ENTRY_W bits.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    W_ISSUE = 2'd1,
    W_WAIT  = 2'd2,
    R_WAIT  = 2'd3
  } wb_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int ENTRY_W   = 66;
  localparam int WDATA_LSB = 0;
  localparam int SIZE_LSB  = 32;
  localparam int ADDR_LSB  = 34;

endpackage

// File: rtl/wb_fifo.sv
// Register FIFO for buffered writes: synchronous write, combinational head read.
// Push is ignored when full and pop when empty, so callers may assert them freely.
module wb_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 66,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/data_write_buffer.sv
// Posted-write buffer: acks stores one cycle after acceptance and drains them
// in order downstream; reads pass through only once every store has landed.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | downstream not busy
// W_ISSUE | requesting downstream with the FIFO head
// W_WAIT  | head accepted, waiting for its dn_data_ok
// R_WAIT  | read forwarded, waiting for its dn_data_ok
module data_write_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up_req,
  input  logic        up_wr,
  input  logic [1:0]  up_size,
  input  logic [31:0] up_addr,
  input  logic [31:0] up_wdata,
  output logic [31:0] up_rdata,
  output logic        up_addr_ok,
  output logic        up_data_ok,
  output logic        dn_req,
  output logic        dn_wr,
  output logic [1:0]  dn_size,
  output logic [31:0] dn_addr,
  output logic [31:0] dn_wdata,
  input  logic [31:0] dn_rdata,
  input  logic        dn_addr_ok,
  input  logic        dn_data_ok,
  output logic        buf_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_state_e          state_q, state_d;
  logic               wr_ack_q, wr_ack_d;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_head, fifo_wentry;
  logic [PTR_W:0]     fifo_count;
  logic               live, wr_hs, rd_fwd, rd_hs;

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wentry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head),
    .count (fifo_count)
  );

  // Nothing is accepted or issued while reset is being applied.
  assign live = ~rst;

  assign wr_hs  = live & up_req & up_wr & ~fifo_full & (state_q != R_WAIT);
  assign rd_fwd = live & up_req & ~up_wr & (state_q == IDLE) & fifo_empty & ~wr_ack_q;
  assign rd_hs  = rd_fwd & dn_addr_ok;

  assign fifo_push   = wr_hs;
  assign fifo_wentry = {up_addr, up_size, up_wdata};
  assign wr_ack_d    = wr_hs;

  assign up_addr_ok = wr_hs | rd_hs;
  assign up_data_ok = live & (wr_ack_q | ((state_q == R_WAIT) & dn_data_ok));
  assign up_rdata   = (live & (state_q == R_WAIT) & dn_data_ok) ? dn_rdata : 32'h0;
  assign buf_empty  = rst | (fifo_empty & (state_q == IDLE) & ~wr_ack_q);

  // Draining wins over a waiting read: reads only forward once the FIFO is empty.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty)  state_d = W_ISSUE;
        else if (rd_hs)   state_d = R_WAIT;
      end
      W_ISSUE: begin
        if (dn_addr_ok)   state_d = W_WAIT;
      end
      W_WAIT: begin
        if (dn_data_ok) begin
          fifo_pop = 1'b1;
          state_d  = (fifo_count > (PTR_W+1)'(1)) ? W_ISSUE : IDLE;
        end
      end
      R_WAIT: begin
        if (dn_data_ok)   state_d = IDLE;
      end
      default:            state_d = IDLE;
    endcase
  end

  always_comb begin
    dn_req   = 1'b0;
    dn_wr    = 1'b0;
    dn_size  = 2'b00;
    dn_addr  = 32'h0;
    dn_wdata = 32'h0;
    if (live && state_q == W_ISSUE) begin
      dn_req   = 1'b1;
      dn_wr    = 1'b1;
      dn_size  = fifo_head[SIZE_LSB +: 2];
      dn_addr  = fifo_head[ADDR_LSB +: 32];
      dn_wdata = fifo_head[WDATA_LSB +: 32];
    end else if (rd_fwd) begin
      dn_req   = 1'b1;
      dn_size  = up_size;
      dn_addr  = up_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ack_q <= wr_ack_d;
    end
  end

endmodule

// File: tb/tb_data_write_buffer.sv
// Randomized bench for data_write_buffer against a queue-based model of the
// posted-write contract, plus directed scenarios for latency and ordering.
module tb_data_write_buffer;

  localparam int DEPTH = 4;

  logic        clk, rst;
  logic        up_req, up_wr;
  logic [1:0]  up_size;
  logic [31:0] up_addr, up_wdata, up_rdata;
  logic        up_addr_ok, up_data_ok;
  logic        dn_req, dn_wr;
  logic [1:0]  dn_size;
  logic [31:0] dn_addr, dn_wdata, dn_rdata;
  logic        dn_addr_ok, dn_data_ok;
  logic        buf_empty;

  data_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_req     (up_req),
    .up_wr      (up_wr),
    .up_size    (up_size),
    .up_addr    (up_addr),
    .up_wdata   (up_wdata),
    .up_rdata   (up_rdata),
    .up_addr_ok (up_addr_ok),
    .up_data_ok (up_data_ok),
    .dn_req     (dn_req),
    .dn_wr      (dn_wr),
    .dn_size    (dn_size),
    .dn_addr    (dn_addr),
    .dn_wdata   (dn_wdata),
    .dn_rdata   (dn_rdata),
    .dn_addr_ok (dn_addr_ok),
    .dn_data_ok (dn_data_ok),
    .buf_empty  (buf_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model: stores accepted but not yet completed downstream, in program order.
  op_t wq[$];
  op_t ops[$];
  bit  ack_pend, rd_out;
  bit  slv_busy, slv_is_wr, slv_stale;
  int  slv_lat;
  int  accept_pct, req_pct, lat_min, lat_max;

  bit          m_active, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;

  int          up_wr_hs[$], up_rd_hs[$], wr_done[$], rd_done[$], dn_cyc[$];
  logic [31:0] dn_log[$];
  int          dok_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clr_logs();
    up_wr_hs.delete(); up_rd_hs.delete(); wr_done.delete();
    rd_done.delete(); dn_cyc.delete(); dn_log.delete();
    dok_cnt = 0;
  endtask

  function automatic op_t mk(input bit wr, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata);
    op_t o;
    o.wr = wr; o.size = size; o.addr = addr; o.wdata = wdata;
    return o;
  endfunction

  task automatic tick();
    bit  rd_cpl, dn_hs, busy0, exp_ok;
    op_t o;
    @(negedge clk);
    cyc++;
    dn_data_ok = slv_busy && (slv_lat == 0);
    dn_rdata   = dn_data_ok ? $urandom : 32'h0;
    dn_addr_ok = ($urandom_range(99) < accept_pct);
    if (!m_active) begin
      if (ops.size() > 0) begin
        o = ops.pop_front();
        m_active = 1'b1; m_wr = o.wr; m_size = o.size; m_addr = o.addr; m_wdata = o.wdata;
      end else if ($urandom_range(99) < req_pct) begin
        m_active = 1'b1;
        m_wr     = ($urandom_range(99) < 60);
        m_size   = 2'($urandom_range(2));
        m_addr   = {24'h000010, 6'($urandom_range(63)), 2'b00};
        m_wdata  = $urandom;
      end
    end
    up_req = m_active; up_wr = m_wr; up_size = m_size; up_addr = m_addr; up_wdata = m_wdata;
    #1;

    rd_cpl = rd_out && dn_data_ok;
    chk("data_ok", 32'(up_data_ok), 32'(ack_pend || rd_cpl));
    if (rd_cpl)   chk("read_data", up_rdata, dn_rdata);
    if (ack_pend) chk("ack_rdata_zero", up_rdata, 32'h0);
    if (up_data_ok) dok_cnt++;
    if (m_active) begin
      if (m_wr) exp_ok = (wq.size() < DEPTH) && !rd_out;
      else      exp_ok = (wq.size() == 0) && !ack_pend && !rd_out && dn_addr_ok;
      chk(m_wr ? "wr_addr_ok" : "rd_addr_ok", 32'(up_addr_ok), 32'(exp_ok));
    end else begin
      chk("idle_addr_ok", 32'(up_addr_ok), 32'h0);
    end
    chk("buf_empty", 32'(buf_empty), 32'((wq.size() == 0) && !ack_pend && !rd_out));

    dn_hs = dn_req && dn_addr_ok;
    busy0 = slv_busy;
    if (slv_busy) begin
      chk("single_outstanding", 32'(dn_req), 32'h0);
    end else if (dn_hs) begin
      if (wq.size() > 0) begin
        chk("dn_wr_flag", 32'(dn_wr), 32'h1);
        chk("dn_wr_addr", dn_addr, wq[0].addr);
        chk("dn_wr_size", 32'(dn_size), 32'(wq[0].size));
        chk("dn_wr_data", dn_wdata, wq[0].wdata);
      end else if (m_active && !m_wr) begin
        chk("dn_rd_flag", 32'(dn_wr), 32'h0);
        chk("dn_rd_addr", dn_addr, m_addr);
        chk("dn_rd_size", 32'(dn_size), 32'(m_size));
      end else begin
        chk("spurious_dn_req", 32'(dn_req), 32'h0);
      end
    end

    if (dn_data_ok) begin
      if (!slv_stale) begin
        if (slv_is_wr) begin
          if (wq.size() > 0) void'(wq.pop_front());
          wr_done.push_back(cyc);
        end else begin
          rd_out = 1'b0;
          rd_done.push_back(cyc);
        end
      end
      slv_busy = 1'b0; slv_stale = 1'b0;
    end else if (slv_busy) begin
      slv_lat--;
    end
    ack_pend = 1'b0;
    if (m_active && up_addr_ok) begin
      if (m_wr) begin
        wq.push_back(mk(1'b1, m_size, m_addr, m_wdata));
        ack_pend = 1'b1;
        up_wr_hs.push_back(cyc);
      end else begin
        up_rd_hs.push_back(cyc);
      end
      m_active = 1'b0;
    end
    if (dn_hs && !busy0) begin
      slv_busy  = 1'b1;
      slv_is_wr = dn_wr;
      slv_lat   = $urandom_range(lat_max, lat_min);
      if (!dn_wr) rd_out = 1'b1;
      dn_log.push_back(dn_addr);
      dn_cyc.push_back(cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; up_req = 1'b0; dn_addr_ok = 1'b0; dn_data_ok = 1'b0;
    m_active = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wq.delete(); ops.delete();
    ack_pend = 1'b0; rd_out = 1'b0;
    #1;
    chk("rst_buf_empty", 32'(buf_empty), 32'h1);
    chk("rst_addr_ok", 32'(up_addr_ok), 32'h0);
    chk("rst_data_ok", 32'(up_data_ok), 32'h0);
    chk("rst_dn_req", 32'(dn_req), 32'h0);
  endtask

  function automatic bit quiet();
    return wq.size() == 0 && !rd_out && !ack_pend && !m_active && ops.size() == 0 && !slv_busy;
  endfunction

  task automatic drain(input string tag);
    req_pct = 0; accept_pct = 100;
    for (int i = 0; i < 300 && !quiet(); i++) tick();
    chk(tag, 32'(quiet()), 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; up_req = 1'b0; up_wr = 1'b0; up_size = 2'b0; up_addr = '0; up_wdata = '0;
    dn_rdata = '0; dn_addr_ok = 1'b0; dn_data_ok = 1'b0;
    m_active = 1'b0; m_wr = 1'b0; m_size = '0; m_addr = '0; m_wdata = '0;
    ack_pend = 0; rd_out = 0; slv_busy = 0; slv_is_wr = 0; slv_stale = 0; slv_lat = 0;
    accept_pct = 100; req_pct = 0; lat_min = 0; lat_max = 0;
    clr_logs();
    repeat (2) @(posedge clk);
    do_reset();

    // Single word store: ack next cycle, issued the cycle after.
    clr_logs();
    lat_min = 2; lat_max = 2; accept_pct = 100; req_pct = 0;
    ops.push_back(mk(1'b1, 2'd2, 32'h1fc0_0100, 32'hdead_beef));
    for (int i = 0; i < 30 && wr_done.size() < 1; i++) tick();
    chk("t2_done", 32'(wr_done.size()), 32'd1);
    if (dn_cyc.size() > 0 && up_wr_hs.size() > 0) begin
      chk("t2_issue_latency", 32'(dn_cyc[0] - up_wr_hs[0]), 32'd2);
      chk("t2_dn_addr", dn_log[0], 32'h1fc0_0100);
    end
    tick();
    chk("t2_buf_empty_after", 32'(buf_empty), 32'h1);
    drain("t2_drain");

    // Five back-to-back stores with downstream stalled.
    clr_logs();
    lat_min = 1; lat_max = 1; accept_pct = 0; req_pct = 0;
    for (int i = 0; i < 5; i++)
      ops.push_back(mk(1'b1, 2'd2, 32'h0000_2000 + 32'(i * 4), 32'h5500_0000 + 32'(i)));
    repeat (8) tick();
    chk("t3_accepted_while_stalled", 32'(up_wr_hs.size()), 32'd4);
    if (up_wr_hs.size() >= 4)
      chk("t3_consecutive", 32'(up_wr_hs[3] - up_wr_hs[0]), 32'd3);
    accept_pct = 100;
    for (int i = 0; i < 100 && wr_done.size() < 5; i++) tick();
    chk("t3_all_done", 32'(wr_done.size()), 32'd5);
    if (up_wr_hs.size() == 5 && wr_done.size() > 0)
      chk("t3_fifth_after_pop", 32'(up_wr_hs[4]), 32'(wr_done[0] + 1));
    for (int i = 0; i < 5 && i < dn_log.size(); i++)
      chk("t3_order", dn_log[i], 32'h0000_2000 + 32'(i * 4));
    drain("t3_drain");

    // Store then load to the same address.
    clr_logs();
    lat_min = 2; lat_max = 2; accept_pct = 100;
    ops.push_back(mk(1'b1, 2'd2, 32'h0000_0100, 32'hcafe_f00d));
    ops.push_back(mk(1'b0, 2'd2, 32'h0000_0100, 32'h0));
    for (int i = 0; i < 60 && rd_done.size() < 1; i++) tick();
    chk("t4_read_done", 32'(rd_done.size()), 32'd1);
    if (up_rd_hs.size() > 0 && wr_done.size() > 0)
      chk("t4_read_after_store", 32'(up_rd_hs[0]), 32'(wr_done[0] + 1));
    drain("t4_drain");

    // Load with empty buffer; a store presented during R_WAIT waits.
    clr_logs();
    lat_min = 5; lat_max = 5; accept_pct = 100;
    ops.push_back(mk(1'b0, 2'd2, 32'h0000_0200, 32'h0));
    ops.push_back(mk(1'b1, 2'd1, 32'h0000_0204, 32'h0000_1234));
    for (int i = 0; i < 40 && up_wr_hs.size() < 1; i++) tick();
    tick();
    chk("t5_store_accepted", 32'(up_wr_hs.size()), 32'd1);
    if (up_wr_hs.size() > 0 && rd_done.size() > 0)
      chk("t5_store_after_read", 32'(up_wr_hs[0]), 32'(rd_done[0] + 1));
    chk("t5_data_ok_pulses", 32'(dok_cnt), 32'd2);
    drain("t5_drain");

    // Randomized traffic.
    clr_logs();
    lat_min = 0; lat_max = 4; accept_pct = 60; req_pct = 70;
    repeat (3000) tick();
    drain("rand_drain");

    // Reset while waiting on a store with three buffered; late dn_data_ok ignored.
    clr_logs();
    lat_min = 20; lat_max = 20; accept_pct = 100; req_pct = 0;
    for (int i = 0; i < 3; i++)
      ops.push_back(mk(1'b1, 2'd2, 32'h0000_3000 + 32'(i * 4), $urandom));
    for (int i = 0; i < 20 && !(slv_busy && wq.size() == 3); i++) tick();
    chk("t6_setup", 32'(slv_busy && wq.size() == 3), 32'h1);
    do_reset();
    slv_stale = slv_busy; slv_lat = 0;
    dok_cnt = 0;
    repeat (4) tick();
    chk("t6_late_data_ok", 32'(dok_cnt), 32'd0);
    chk("t6_buf_empty", 32'(buf_empty), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
